// File: rtl/axi_rd_stream_engine.sv
// axi_rd_stream_engine: multi-burst AXI4 read engine feeding an in-order stream.
// Define AXI_RD_PERF_EN to add the perf_cycles / perf_ar_stall counters.
module axi_rd_stream_engine #(
    parameter int ENGINE_ID       = 0,
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 6,
    parameter int LEN_WIDTH       = 8,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_axi_ARVALID,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [LEN_WIDTH-1:0]  m_axi_ARLEN,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    input  logic                  m_axi_ARREADY,
    input  logic                  m_axi_RVALID,
    input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
    input  logic                  m_axi_RLAST,
    input  logic [ID_WIDTH-1:0]   m_axi_RID,
    input  logic [1:0]            m_axi_RRESP,
    output logic                  m_axi_RREADY
`ifdef AXI_RD_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_ar_stall
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int LW    = $clog2(BURST_LEN + 1);
    localparam int DEPTH = MAX_OUTSTANDING * BURST_LEN;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int QW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW    = ADDR_WIDTH - OFFW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
    logic [LW-1:0]         arbeats_q, arbeats_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         infl_q, infl_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [QW-1:0]         lq_wp_q, lq_wp_d, lq_rp_q, lq_rp_d;
    logic [OW-1:0]         lq_cnt_q, lq_cnt_d;
    logic [LW-1:0]         rbeat_q, rbeat_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]         lq_mem [MAX_OUTSTANDING];

    logic                  accept, ar_hs, r_hs, push, pop, launch;
    logic                  drained, exp_last, lq_pop, r_bad;
    logic [BW-1:0]         beat_addr;
    logic [CNT_WIDTH-1:0]  off, room, len_c;
    logic [CW-1:0]         credits;
    logic [LW-1:0]         head_len;

    assign accept    = (state_q == IDLE) && start;
    assign ar_hs     = arvalid_q && m_axi_ARREADY;
    assign r_hs      = m_axi_RVALID;
    assign push      = r_hs && (cnt_q != CW'(DEPTH));
    assign pop       = (cnt_q != '0) && m_ready;
    assign drained   = (infl_q == '0) && (cnt_q == '0);

    // Burst length: stop at the aligned BURST_LEN window so no 4 KB crossing.
    assign beat_addr = addr_q[ADDR_WIDTH-1:OFFW];
    assign off       = CNT_WIDTH'(beat_addr & BW'(BURST_LEN - 1));
    assign room      = CNT_WIDTH'(BURST_LEN) - off;
    assign len_c     = (rem_q < room) ? rem_q : room;
    assign credits   = CW'(DEPTH) - (cnt_q + infl_q);

    assign launch    = (state_q == ISSUE) && !arvalid_q && (rem_q != '0)
                     && (outst_q < OW'(MAX_OUTSTANDING))
                     && (lq_cnt_q < OW'(MAX_OUTSTANDING))
                     && (CNT_WIDTH'(credits) >= len_c);

    assign head_len  = lq_mem[lq_rp_q];
    assign exp_last  = (rbeat_q + LW'(1)) == head_len;
    assign lq_pop    = r_hs && (lq_cnt_q != '0) && exp_last;
    assign r_bad     = (m_axi_RRESP != 2'b00)
                     || (m_axi_RID != ID_WIDTH'(ENGINE_ID))
                     || ((lq_cnt_q != '0) && (m_axi_RLAST != exp_last));

    // Command FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if ((rem_q == '0) && !arvalid_q)
                         state_d = drained ? DONE : DRAIN;
            DRAIN:   if (drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: AR issue, credit/outstanding tracking, FIFO pointers.
    always_comb begin
        addr_d    = addr_q;
        rem_d     = rem_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arbeats_d = arbeats_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        lq_wp_d   = lq_wp_q;
        lq_rp_d   = lq_rp_q;
        rbeat_d   = rbeat_q;
        err_d     = err_q;
        if (accept) begin
            addr_d = base_addr & ~ADDR_WIDTH'(BYTES - 1);
            rem_d  = num_beats;
            err_d  = 1'b0;
        end
        if (launch) begin
            arvalid_d = 1'b1;
            araddr_d  = addr_q;
            arlen_d   = LEN_WIDTH'(len_c - CNT_WIDTH'(1));
            arbeats_d = LW'(len_c);
        end
        if (ar_hs) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + (ADDR_WIDTH'(arbeats_q) << OFFW);
            rem_d     = rem_q - CNT_WIDTH'(arbeats_q);
            lq_wp_d   = (lq_wp_q == QW'(MAX_OUTSTANDING - 1)) ? '0 : lq_wp_q + QW'(1);
        end
        if (r_hs && (lq_cnt_q != '0))
            rbeat_d = exp_last ? '0 : rbeat_q + LW'(1);
        if (lq_pop)
            lq_rp_d = (lq_rp_q == QW'(MAX_OUTSTANDING - 1)) ? '0 : lq_rp_q + QW'(1);
        if (r_hs && r_bad)
            err_d = 1'b1;
        if (push)
            wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
        if (pop)
            rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        infl_d   = infl_q + (ar_hs ? CW'(arbeats_q) : '0)
                 - CW'(r_hs && (infl_q != '0));
        outst_d  = outst_q + OW'(ar_hs)
                 - OW'(r_hs && m_axi_RLAST && (outst_q != '0));
        lq_cnt_d = lq_cnt_q + OW'(ar_hs) - OW'(lq_pop);
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arbeats_q <= '0;
            outst_q   <= '0;
            infl_q    <= '0;
            cnt_q     <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            lq_wp_q   <= '0;
            lq_rp_q   <= '0;
            lq_cnt_q  <= '0;
            rbeat_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arbeats_q <= arbeats_d;
            outst_q   <= outst_d;
            infl_q    <= infl_d;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            lq_wp_q   <= lq_wp_d;
            lq_rp_q   <= lq_rp_d;
            lq_cnt_q  <= lq_cnt_d;
            rbeat_q   <= rbeat_d;
            err_q     <= err_d;
        end
    end

    // Storage: stream data FIFO and per-burst length queue (no reset needed).
    always_ff @(posedge clk) begin
        if (push)
            mem[wp_q] <= m_axi_RDATA;
        if (ar_hs)
            lq_mem[lq_wp_q] <= arbeats_q;
    end

`ifdef AXI_RD_PERF_EN
    logic [31:0] pcyc_q, pstall_q;

    // Perf counters: clear on accept, hold after done, saturate at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcyc_q   <= '0;
            pstall_q <= '0;
        end else begin
            if (accept)
                pcyc_q <= 32'd1;
            else if ((state_q != IDLE) && (pcyc_q != '1))
                pcyc_q <= pcyc_q + 32'd1;
            if (accept)
                pstall_q <= '0;
            else if (arvalid_q && !m_axi_ARREADY && (pstall_q != '1))
                pstall_q <= pstall_q + 32'd1;
        end
    end

    assign perf_cycles   = pcyc_q;
    assign perf_ar_stall = pstall_q;
`endif

    assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign m_data        = mem[rp_q];
    assign m_valid       = (cnt_q != '0);
    assign m_axi_ARVALID = arvalid_q;
    assign m_axi_ARADDR  = araddr_q;
    assign m_axi_ARLEN   = arlen_q;
    assign m_axi_ARID    = ID_WIDTH'(ENGINE_ID);
    assign m_axi_ARSIZE  = 3'(OFFW);
    assign m_axi_ARBURST = 2'b01;
    assign m_axi_RREADY  = 1'b1;

endmodule

// File: tb/tb_axi_rd_stream_engine.sv
// tb_axi_rd_stream_engine: directed vectors and corner sequences for the
// AXI read stream engine, with a small AXI slave model and stream monitor.
module tb_axi_rd_stream_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [32:0]  base_addr;
    logic [31:0]  num_beats;
    logic         busy, done, err;
    logic [255:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_axi_ARVALID;
    logic [32:0]  m_axi_ARADDR;
    logic [5:0]   m_axi_ARID;
    logic [7:0]   m_axi_ARLEN;
    logic [2:0]   m_axi_ARSIZE;
    logic [1:0]   m_axi_ARBURST;
    logic         m_axi_ARREADY;
    logic         m_axi_RVALID;
    logic [255:0] m_axi_RDATA;
    logic         m_axi_RLAST;
    logic [5:0]   m_axi_RID;
    logic [1:0]   m_axi_RRESP;
    logic         m_axi_RREADY;

    axi_rd_stream_engine dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_beats     (num_beats),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_axi_ARVALID (m_axi_ARVALID),
        .m_axi_ARADDR  (m_axi_ARADDR),
        .m_axi_ARID    (m_axi_ARID),
        .m_axi_ARLEN   (m_axi_ARLEN),
        .m_axi_ARSIZE  (m_axi_ARSIZE),
        .m_axi_ARBURST (m_axi_ARBURST),
        .m_axi_ARREADY (m_axi_ARREADY),
        .m_axi_RVALID  (m_axi_RVALID),
        .m_axi_RDATA   (m_axi_RDATA),
        .m_axi_RLAST   (m_axi_RLAST),
        .m_axi_RID     (m_axi_RID),
        .m_axi_RRESP   (m_axi_RRESP),
        .m_axi_RREADY  (m_axi_RREADY)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [32:0] base;
        logic [31:0] num;
        logic [1:0]  arr;
        logic [1:0]  mr;
        logic [7:0]  lat;
        logic [7:0]  errb;
        logic [7:0]  ars;
        logic [32:0] faddr;
        logic [7:0]  flen;
        logic [32:0] laddr;
        logic [7:0]  llen;
        logic        eerr;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] n;
        logic [31:0] rdy;
    } burst_t;

    vec_t   vecs [7];
    burst_t pend [$];

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int cfg_arr = 0, cfg_mr = 0, cfg_lat = 10, cfg_errb = 255;
    int ar_cnt, pop_cnt, done_cnt, data_mism, rb, rtot;
    logic [32:0] f_addr, l_addr, prev_addr;
    int          f_len, l_len;
    logic [7:0]  prev_len;
    logic        prev_stall = 1'b0;
    logic [31:0] exp_base;
    logic [31:0] exp_d;
    logic        ar_rdy, mr;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        ar_cnt    = 0;
        pop_cnt   = 0;
        done_cnt  = 0;
        data_mism = 0;
        rtot      = 0;
        f_addr    = '0;
        l_addr    = '0;
        f_len     = -1;
        l_len     = -1;
    endtask

    task automatic start_cmd(input logic [32:0] b, input logic [31:0] n);
        start     = 1'b1;
        base_addr = b;
        num_beats = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int n = 0;
        while (done_cnt == 0 && n < maxc) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 64'(done_cnt != 0), 64'd1);
    endtask

    // AXI slave model and stream monitor, sampled 1 time unit after each edge.
    initial begin
        m_axi_ARREADY = 1'b1;
        m_axi_RVALID  = 1'b0;
        m_axi_RDATA   = '0;
        m_axi_RLAST   = 1'b0;
        m_axi_RID     = '0;
        m_axi_RRESP   = 2'b00;
        m_ready       = 1'b1;
        rb            = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev_stall) begin
                chk("ar_hold_valid", 64'(m_axi_ARVALID), 64'd1);
                chk("ar_hold_addr", 64'(m_axi_ARADDR), 64'(prev_addr));
                chk("ar_hold_len", 64'(m_axi_ARLEN), 64'(prev_len));
            end
            ar_rdy = (cfg_arr == 0) ? 1'b1 : cyc[0];
            m_axi_ARREADY = ar_rdy;
            mr = (cfg_mr == 0) ? 1'b1 : (cfg_mr == 1) ? (cyc % 3 != 0) : 1'b0;
            m_ready = mr;
            prev_stall = !reset && m_axi_ARVALID && !ar_rdy;
            prev_addr  = m_axi_ARADDR;
            prev_len   = m_axi_ARLEN;
            if (reset) begin
                pend.delete();
                rb           = 0;
                m_axi_RVALID = 1'b0;
                m_axi_RLAST  = 1'b0;
                m_axi_RRESP  = 2'b00;
            end else begin
                if (m_axi_ARVALID && ar_rdy) begin
                    ar_cnt++;
                    if (ar_cnt == 1) begin
                        f_addr = m_axi_ARADDR;
                        f_len  = int'(m_axi_ARLEN);
                    end
                    l_addr = m_axi_ARADDR;
                    l_len  = int'(m_axi_ARLEN);
                    pend.push_back({m_axi_ARADDR[31:0],
                                    32'(m_axi_ARLEN) + 32'd1,
                                    32'(cyc + cfg_lat)});
                end
                if (pend.size() > 0 && pend[0].rdy <= 32'(cyc)) begin
                    m_axi_RVALID = 1'b1;
                    m_axi_RDATA  = {8{pend[0].a + 32'(rb * 32)}};
                    m_axi_RLAST  = (32'(rb) == pend[0].n - 32'd1);
                    m_axi_RRESP  = (rtot == cfg_errb) ? 2'b10 : 2'b00;
                    rtot++;
                    rb++;
                    if (32'(rb) == pend[0].n) begin
                        void'(pend.pop_front());
                        rb = 0;
                    end
                end else begin
                    m_axi_RVALID = 1'b0;
                    m_axi_RLAST  = 1'b0;
                    m_axi_RRESP  = 2'b00;
                end
                if (m_valid && mr) begin
                    exp_d = exp_base + 32'(pop_cnt * 32);
                    if (m_data !== {8{exp_d}})
                        data_mism++;
                    pop_cnt++;
                end
                if (done)
                    done_cnt++;
            end
        end
    end

    initial begin
        // base, num, arr, mr, lat, errb, ars, faddr, flen, laddr, llen, err
        vecs[0] = '{33'h0, 32'd40, 2'd0, 2'd0, 8'd10, 8'd255, 8'd3,
                    33'h0, 8'd15, 33'h400, 8'd7, 1'b0};
        vecs[1] = '{33'h1E0, 32'd3, 2'd0, 2'd0, 8'd10, 8'd255, 8'd2,
                    33'h1E0, 8'd0, 33'h200, 8'd1, 1'b0};
        vecs[2] = '{33'h1E7, 32'd1, 2'd0, 2'd0, 8'd4, 8'd255, 8'd1,
                    33'h1E0, 8'd0, 33'h1E0, 8'd0, 1'b0};
        vecs[3] = '{33'h100, 32'd20, 2'd1, 2'd1, 8'd3, 8'd255, 8'd2,
                    33'h100, 8'd7, 33'h200, 8'd11, 1'b0};
        vecs[4] = '{33'h0, 32'd16, 2'd0, 2'd0, 8'd10, 8'd5, 8'd1,
                    33'h0, 8'd15, 33'h0, 8'd15, 1'b1};
        vecs[5] = '{33'h1_FFFF_FE00, 32'd32, 2'd0, 2'd0, 8'd6, 8'd255, 8'd2,
                    33'h1_FFFF_FE00, 8'd15, 33'h0, 8'd15, 1'b0};
        vecs[6] = '{33'hFE0, 32'd2, 2'd0, 2'd0, 8'd2, 8'd255, 8'd2,
                    33'hFE0, 8'd0, 33'h1000, 8'd0, 1'b0};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_beats = '0;
        clear_mon();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_arvalid", 64'(m_axi_ARVALID), 64'd0);
        chk("rst_araddr", 64'(m_axi_ARADDR), 64'd0);
        chk("rst_arlen", 64'(m_axi_ARLEN), 64'd0);
        chk("rst_rready", 64'(m_axi_RREADY), 64'd1);
        chk("arid", 64'(m_axi_ARID), 64'd0);
        chk("arsize", 64'(m_axi_ARSIZE), 64'd5);
        chk("arburst", 64'(m_axi_ARBURST), 64'd1);

        for (int i = 0; i < 7; i++) begin
            cfg_arr  = int'(vecs[i].arr);
            cfg_mr   = int'(vecs[i].mr);
            cfg_lat  = int'(vecs[i].lat);
            cfg_errb = int'(vecs[i].errb);
            clear_mon();
            exp_base = vecs[i].base[31:0] & ~32'd31;
            start_cmd(vecs[i].base, vecs[i].num);
            wait_done($sformatf("v%0d", i), 3000);
            repeat (3) tick();
            chk($sformatf("v%0d_ar_count", i), 64'(ar_cnt), 64'(vecs[i].ars));
            chk($sformatf("v%0d_first_addr", i), 64'(f_addr), 64'(vecs[i].faddr));
            chk($sformatf("v%0d_first_len", i), 64'(f_len), 64'(vecs[i].flen));
            chk($sformatf("v%0d_last_addr", i), 64'(l_addr), 64'(vecs[i].laddr));
            chk($sformatf("v%0d_last_len", i), 64'(l_len), 64'(vecs[i].llen));
            chk($sformatf("v%0d_beats", i), 64'(pop_cnt), 64'(vecs[i].num));
            chk($sformatf("v%0d_data_bad", i), 64'(data_mism), 64'd0);
            chk($sformatf("v%0d_done_pulses", i), 64'(done_cnt), 64'd1);
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].eerr));
        end

        // Zero-beat command: done exactly two cycles after accept, no AR.
        cfg_arr = 0; cfg_mr = 0; cfg_lat = 10; cfg_errb = 255;
        clear_mon();
        exp_base = '0;
        start_cmd(33'h0, 32'd0);
        chk("zero_busy_c1", 64'(busy), 64'd1);
        chk("zero_done_c1", 64'(done), 64'd0);
        tick();
        chk("zero_done_c2", 64'(done), 64'd1);
        chk("zero_busy_c2", 64'(busy), 64'd0);
        tick();
        chk("zero_done_c3", 64'(done), 64'd0);
        repeat (3) tick();
        chk("zero_ar_count", 64'(ar_cnt), 64'd0);

        // Start while busy is ignored.
        clear_mon();
        exp_base = '0;
        start_cmd(33'h0, 32'd40);
        repeat (3) tick();
        start_cmd(33'h800, 32'd5);
        wait_done("busy_start", 3000);
        repeat (20) tick();
        chk("busy_start_ar_count", 64'(ar_cnt), 64'd3);
        chk("busy_start_beats", 64'(pop_cnt), 64'd40);
        chk("busy_start_data_bad", 64'(data_mism), 64'd0);
        chk("busy_start_done", 64'(done_cnt), 64'd1);

        // Stream stalled: credits cap issue at 64 beats, then full recovery.
        cfg_mr = 2;
        clear_mon();
        exp_base = '0;
        start_cmd(33'h0, 32'd200);
        repeat (150) tick();
        chk("stall_ar_count", 64'(ar_cnt), 64'd4);
        chk("stall_arvalid", 64'(m_axi_ARVALID), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        cfg_mr = 0;
        wait_done("stall", 5000);
        repeat (3) tick();
        chk("stall_beats", 64'(pop_cnt), 64'd200);
        chk("stall_data_bad", 64'(data_mism), 64'd0);
        chk("stall_total_ars", 64'(ar_cnt), 64'd13);
        chk("stall_last_len", 64'(l_len), 64'd7);
        chk("stall_done", 64'(done_cnt), 64'd1);

        // Reset during drain with data still buffered.
        cfg_mr = 2; cfg_lat = 5;
        clear_mon();
        exp_base = '0;
        start_cmd(33'h0, 32'd16);
        repeat (40) tick();
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_mvalid", 64'(m_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_mvalid", 64'(m_valid), 64'd0);
        chk("mid_rst_arvalid", 64'(m_axi_ARVALID), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        cfg_mr = 0;
        tick();
        clear_mon();
        exp_base = 32'h400;
        start_cmd(33'h400, 32'd16);
        wait_done("after_rst", 3000);
        repeat (3) tick();
        chk("after_rst_beats", 64'(pop_cnt), 64'd16);
        chk("after_rst_data_bad", 64'(data_mism), 64'd0);
        chk("after_rst_ar_count", 64'(ar_cnt), 64'd1);
        chk("after_rst_done", 64'(done_cnt), 64'd1);
        chk("after_rst_err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_stream_engine.md
Name: axi_rd_stream_engine

Overview:
Parametrised read-side successor to the single-beat AXI engine. One `start` command fetches an arbitrary number of beats (`num_beats`) from a byte address, split into INCR bursts of up to BURST_LEN beats. The engine keeps up to MAX_OUTSTANDING bursts in flight and delivers the data in order on a valid/ready stream. It sits between a compute kernel and one HBM/DDR4 AXI port.

Parameters:
ENGINE_ID, 0, constant driven on ARID; expected on RID
ADDR_WIDTH, 33, byte address width
DATA_WIDTH, 256, AXI/stream data width; BYTES = DATA_WIDTH/8
ID_WIDTH, 6, AXI ID width
LEN_WIDTH, 8, ARLEN width
BURST_LEN, 16, max beats per burst; power of 2; BURST_LEN*BYTES <= 4096
MAX_OUTSTANDING, 4, max accepted-but-incomplete bursts
CNT_WIDTH, 32, width of the beat count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; accepted only when busy=0
base_addr  in  ADDR_WIDTH  start byte address, sampled on accept
num_beats  in  CNT_WIDTH  total beats to read, sampled on accept
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse at end of command
err  out  1  sticky error flag; cleared on next accepted start
m_data  out  DATA_WIDTH  read stream data
m_valid  out  1  read stream valid
m_ready  in  1  read stream ready
m_axi_ARVALID  out  1  read address valid
m_axi_ARADDR  out  ADDR_WIDTH  burst byte address
m_axi_ARID  out  ID_WIDTH  equals ENGINE_ID
m_axi_ARLEN  out  LEN_WIDTH  burst beats - 1
m_axi_ARSIZE  out  3  log2(BYTES), constant
m_axi_ARBURST  out  2  2'b01 (INCR), constant
m_axi_ARREADY  in  1  read address ready
m_axi_RVALID  in  1  read data valid
m_axi_RDATA  in  DATA_WIDTH  read data
m_axi_RLAST  in  1  last beat of burst
m_axi_RID  in  ID_WIDTH  read data id
m_axi_RRESP  in  2  read response
m_axi_RREADY  out  1  read data ready

ARLOCK, ARCACHE, ARPROT, ARQOS and ARREGION are not generated here; the wrapper ties them to 0.

Behaviour:
- Reset values: busy, done, err, m_valid, ARVALID = 0; ARADDR, ARLEN = 0; RREADY = 1; FIFO empty; FSM = IDLE.
- FSM states:
  - IDLE: on start, latch `base_addr` with the low log2(BYTES) bits forced to 0, latch `num_beats`, clear err, go to ISSUE. start while busy=1 is ignored.
  - ISSUE: generate bursts until remaining = 0, then go to DRAIN. If `num_beats` = 0, go straight to DONE with no AR.
  - DRAIN: wait until all issued beats have been received and popped from the stream, then go to DONE.
  - DONE: done = 1 for one cycle, busy drops in the same cycle, then go to IDLE.
- Latency: start accepted at cycle 0 → busy = 1 and ARVALID may first be 1 at cycle 1 (all outputs registered).
- Burst sizing: `off` = beat index within the aligned BURST_LEN*BYTES window; `len` = min(remaining, BURST_LEN - off). This guarantees no burst crosses a 4 KB boundary.
  - ARLEN = len - 1.
  - Next address = address + len*BYTES.
  - remaining -= len on each AR handshake.
- AR handshake: ARADDR/ARLEN stay stable while ARVALID = 1 && ARREADY = 0. ARVALID never deasserts without a handshake.
- Issue gating: assert ARVALID only when outstanding < MAX_OUTSTANDING and credits >= len.
- Buffer: FIFO of depth MAX_OUTSTANDING*BURST_LEN.
  - credits = depth - (FIFO occupancy + beats requested but not yet received).
  - AR handshake subtracts len; an m_valid && m_ready pop adds 1; both in the same cycle apply both.
  - RREADY is held at 1; credit gating guarantees space, so an overflow cannot occur.
- Outstanding count: +1 on AR handshake, -1 on an R beat with RLAST; simultaneous events net to 0.
- Stream: FIFO output, first-word fall-through. m_data is held stable while m_valid && !m_ready. Beats leave in request order.
- Errors set err; the data beat is still forwarded:
  - RRESP != 2'b00;
  - RID != ENGINE_ID;
  - RLAST asserted on a beat other than the last beat of the burst, or missing on the last beat.
- Counter widths: remaining is CNT_WIDTH bits. The address wraps modulo 2^ADDR_WIDTH with no error.
- Reset mid-operation: next cycle returns every output to its reset value and flushes the FIFO. In-flight AXI responses are not tracked; the interconnect is reset together with this block.

Optional Feature:
Macro: AXI_RD_PERF_EN.
- When defined, adds two outputs:
  - perf_cycles [31:0]: cycles from accept to done inclusive.
  - perf_ar_stall [31:0]: cycles with ARVALID && !ARREADY.
  - Both clear on accept, hold their value after done, and saturate at all-ones.
- When undefined, both ports and their logic are absent. Functional behaviour is identical either way.

Test Plan:
- Defaults, base_addr = 0x0, num_beats = 40, ARREADY = 1, R latency 10 → ARs (0x000, len 15), (0x200, len 15), (0x400, len 7); 40 beats in order; exactly one done pulse; err = 0.
- base_addr = 0x1E0, num_beats = 3 → ARs (0x1E0, ARLEN 0), then (0x200, ARLEN 1); 3 beats out.
- m_ready = 0 held, num_beats = 200 → exactly 4 ARs (64 beats) issued, then ARVALID stays 0; after m_ready = 1, all 200 beats arrive with none lost or duplicated.
- RRESP = 2'b10 on beat 5 of 16 → err = 1 from that beat, all 16 beats delivered, done pulses; next start clears err.
- num_beats = 0 → done pulse at cycle 2, ARVALID never asserted; start during busy = 1 is ignored.
- reset asserted during DRAIN with the FIFO non-empty → next cycle busy = 0, m_valid = 0, ARVALID = 0; a following start with num_beats = 16 completes normally.
